// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the requester, memory and status signals of the
// line-port arbiter. "slave" is the arbiter's view; "master" is the view of
// the surrounding pipeline and memory (or a testbench standing in for them).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // instruction-fetch refill side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              o_i_done;
  logic [LINE_W-1:0] o_i_rdata;
  // data-cache refill / writeback side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              o_d_done;
  logic [LINE_W-1:0] o_d_rdata;
  // backing-memory line port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  // status for pipeline stall logic
  logic              o_busy;
  logic              o_owner;
  logic              o_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output o_i_done, o_i_rdata, o_d_done, o_d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, o_busy, o_owner, o_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  o_i_done, o_i_rdata, o_d_done, o_d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, o_busy, o_owner, o_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory line port between the instruction
// refill path (read-only) and the data-cache refill/writeback path.
// Transactions are serialised by an IDLE -> BUSY -> RESP FSM; simultaneous
// requests are resolved round-robin against the last granted side.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT cycles without mem_ack (done + o_err, owner's rdata zeroed).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // TIMEOUT has to fit the 16-bit BUSY counter
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..65535");
  end

  state_t            state_q, state_d;
  logic              owner_q, owner_d;     // also serves as last_owner
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data;
  logic              timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Count BUSY cycles; any other state clears, so each BUSY entry starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // The TIMEOUT-th BUSY cycle without an ack is the last one
  assign timeout_hit = (state_q == BUSY) && (tmo_cnt_q == 16'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic; pulses default low every cycle
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_req_d  = 1'b0;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    // data wins when it is the only requester, or on a tie when the
    // instruction side was granted last
    grant_data = bus.d_req && (!bus.i_req || !owner_q);

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d   = grant_data;
          addr_d    = grant_data ? bus.d_addr : bus.i_addr;
          we_d      = grant_data & bus.d_we;   // instruction side never writes
          wdata_d   = grant_data ? bus.d_wdata : '0;
          state_d   = BUSY;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      BUSY: begin
        busy_d = 1'b1;
        if (bus.mem_ack) begin
          // an ack coincident with the timeout still completes normally
          state_d = RESP;
          if (owner_q) begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight transaction at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.o_i_done  = i_done_q;
  assign bus.o_d_done  = d_done_q;
  assign bus.o_i_rdata = i_rdata_q;
  assign bus.o_d_rdata = d_rdata_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_owner   = owner_q;
  assign bus.o_err     = err_q;

endmodule
